axil_regtest_master: RTL and testbench

AXIL_REGTEST_MASTER -- requirements
Module: axil_regtest_master
Interface
REQ-001 The block SHALL have one clock, ACLK, and one reset, ARESETN, which is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 32: AXI4-Lite data width, 32 or 64.
REQ-003 Parameter ADDR_WIDTH, default 32: AXI4-Lite address width.
REQ-004 Parameter NUM_REGS, default 4: registers exercised per run, 1..256.
REQ-005 Parameter BASE_ADDR, default 0: address of register 0.
REQ-006 Parameter PATTERN_SEED, default 32'h0101FFFF, zero-extended to DATA_WIDTH: data written to register 0.
REQ-007 Ports, one per line (name, direction, width, meaning):
 ACLK  in  1  clock
 ARESETN  in  1  async active-low reset
 start  in  1  single-cycle run request
 busy  out  1  run in progress
 done  out  1  run finished, held until next accepted start
 pass  out  1  done with err_count==0
 err_count  out  8  saturating error count
 M_AXI_AWADDR  out  ADDR_WIDTH  write address
 M_AXI_AWVALID  out  1  write address valid
 M_AXI_AWREADY  in  1  write address ready
 M_AXI_WDATA  out  DATA_WIDTH  write data
 M_AXI_WSTRB  out  DATA_WIDTH/8  write strobes, all ones
 M_AXI_WVALID  out  1  write data valid
 M_AXI_WREADY  in  1  write data ready
 M_AXI_BRESP  in  2  write response
 M_AXI_BVALID  in  1  write response valid
 M_AXI_BREADY  out  1  write response ready
 M_AXI_ARADDR  out  ADDR_WIDTH  read address
 M_AXI_ARVALID  out  1  read address valid
 M_AXI_ARREADY  in  1  read address ready
 M_AXI_RDATA  in  DATA_WIDTH  read data
 M_AXI_RRESP  in  2  read response
 M_AXI_RVALID  in  1  read data valid
 M_AXI_RREADY  out  1  read data ready
Function
REQ-008 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, NEXT, DONE. start in IDLE or DONE -> WR_REQ with index k=0, err_count=0, done=0, and busy=1 from the next cycle. start in any other state SHALL be ignored.
REQ-009 Register k address = BASE_ADDR + k*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH. Data: d0 = PATTERN_SEED; d(k+1) = rotate-left-1(dk) + 1, modulo 2^DATA_WIDTH.
REQ-010 Once any VALID is asserted, it and its payload SHALL stay stable until the matching READY handshake, then drop in the following cycle.
REQ-011 WR_RESP: BREADY=1. On the BVALID handshake, go to RD_REQ. BRESP != 2'b00 SHALL count 1 error.
REQ-012 RD_REQ: ARVALID until the handshake, then RD_DATA. RD_DATA: RREADY=1. On the RVALID handshake, RRESP != 2'b00 or RDATA != dk SHALL count exactly 1 error; then go to NEXT.
REQ-013 NEXT: if k==NUM_REGS-1, go to DONE. Otherwise increment k and go to WR_REQ.
REQ-014 DONE: done=1, busy=0, pass=(err_count==0). err_count SHALL saturate at 255.
REQ-015 With an always-ready, zero-latency slave, each register SHALL take 5 cycles in concurrent mode (6 otherwise). done SHALL rise 2 cycles after the final R handshake.
Reset
REQ-016 While ARESETN=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and k=0, including when reset is asserted mid-transaction. No outstanding transaction SHALL be resumed after reset release.
Configuration
REQ-017 Macro AXIL_REGTEST_CONCURRENT_EN:
 - Defined: WR_REQ asserts AWVALID and WVALID in the same cycle. Each deasserts independently on its own handshake. WR_RESP is entered once both handshakes have occurred.
 - Undefined: WVALID is asserted only in the cycle after the AW handshake.
Verification
REQ-018 Default parameters, zero-wait memory slave -> writes to 0x0/0x4/0x8/0xC with data 0x0101FFFF/0x0203FFFF/0x0407FFFF/0x080FFFFF; matching reads; done=1, pass=1, err_count=0.
REQ-019 Slave flips RDATA bit 0 at 0x8 -> err_count=1, pass=0.
REQ-020 Slave returns BRESP=2'b10 on every write -> err_count=4, pass=0.
REQ-021 AWREADY/WREADY/ARREADY with independent random stalls of 0-5 cycles -> payloads stable while VALID is high; result identical to REQ-018. In concurrent mode, check the AW-before-W and W-before-AW orderings.
REQ-022 ARESETN driven low during RD_DATA of k=2 -> all outputs 0 within the same cycle. After release, a new start completes with pass=1.
REQ-023 start while busy -> ignored. start while done -> err_count cleared and a full rerun performed.

---
 rtl/axil_regtest_master.sv | 172 +++++++++++++++++
 tb/tb_axil_regtest_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regtest_master.sv
`timescale 1ns/1ps
// axil_regtest_master: walks NUM_REGS AXI4-Lite registers, writing a rolling pattern to each
// and reading it straight back, counting bad responses and data miscompares.
// Optional macro AXIL_REGTEST_CONCURRENT_EN: present AW and W in the same cycle
// (5 cycles/register). When undefined, W follows the AW handshake (6 cycles/register).
module axil_regtest_master #(
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            NUM_REGS     = 4,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter logic [31:0]            PATTERN_SEED = 32'h0101FFFF
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [7:0]                err_count,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(PATTERN_SEED);
    localparam logic [7:0]            LAST_IDX   = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrResp, StRdReq, StRdData, StNext, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [7:0]              err_q;
    logic                    aw_done_q, w_done_q;

    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic run_start, err_hit;

    // Next-state decode and per-state channel handshake signals
    always_comb begin
        state_d   = state_q;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        run_start = 1'b0;
        err_hit   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StWrReq;
                    run_start = 1'b1;
                end
            end
            StWrReq: begin
                aw_valid = !aw_done_q;
`ifdef AXIL_REGTEST_CONCURRENT_EN
                w_valid  = !w_done_q;
`else
                w_valid  = aw_done_q && !w_done_q;
`endif
                // Each channel completes on its own; leave once both have handshaken
                if ((aw_done_q || (aw_valid && M_AXI_AWREADY)) &&
                    (w_done_q  || (w_valid  && M_AXI_WREADY))) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                b_ready = 1'b1;
                if (M_AXI_BVALID) begin
                    state_d = StRdReq;
                    err_hit = (M_AXI_BRESP != 2'b00);
                end
            end
            StRdReq: begin
                ar_valid = 1'b1;
                if (M_AXI_ARREADY) state_d = StRdData;
            end
            StRdData: begin
                r_ready = 1'b1;
                if (M_AXI_RVALID) begin
                    state_d = StNext;
                    // Bad response and bad data on one beat still count once
                    err_hit = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_q);
                end
            end
            StNext: begin
                state_d = (idx_q == LAST_IDX) ? StDone : StWrReq;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Register index, address, expected pattern and saturating error counter
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx_q  <= 8'd0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 8'd0;
        end else begin
            if (run_start) begin
                idx_q  <= 8'd0;
                addr_q <= BASE_ADDR;
                data_q <= SEED;
                err_q  <= 8'd0;
            end else if (state_q == StNext && idx_q != LAST_IDX) begin
                idx_q  <= idx_q + 8'd1;
                addr_q <= addr_q + ADDR_STEP;
                data_q <= {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]} + DATA_WIDTH'(1);
            end
            if (err_hit && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    // Per-channel completion flags for the current write; cleared outside WR_REQ
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q != StWrReq) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_valid && M_AXI_AWREADY) aw_done_q <= 1'b1;
            if (w_valid && M_AXI_WREADY)   w_done_q  <= 1'b1;
        end
    end

    // Payloads are gated by their VALID so every output reads zero in reset and idle
    assign M_AXI_AWVALID = aw_valid;
    assign M_AXI_AWADDR  = aw_valid ? addr_q : '0;
    assign M_AXI_WVALID  = w_valid;
    assign M_AXI_WDATA   = w_valid ? data_q : '0;
    assign M_AXI_WSTRB   = w_valid ? '1 : '0;
    assign M_AXI_BREADY  = b_ready;
    assign M_AXI_ARVALID = ar_valid;
    assign M_AXI_ARADDR  = ar_valid ? addr_q : '0;
    assign M_AXI_RREADY  = r_ready;

    assign done      = (state_q == StDone);
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign pass      = done && (err_q == 8'd0);
    assign err_count = err_q;

endmodule

// File: tb/tb_axil_regtest_master.sv
`timescale 1ns/1ps
// Bench for axil_regtest_master: memory-like AXI4-Lite slave with per-register fault
// injection and random READY stalls, checked against a pattern/error-count model.
module tb_axil_regtest_master;

    localparam int NREG = 4;
    localparam int STEP = 4;
`ifdef AXIL_REGTEST_CONCURRENT_EN
    localparam int PER = 5;
`else
    localparam int PER = 6;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axil_regtest_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // ---------------- slave configuration (written only by the test process)
    int         aw_lo = 0, aw_hi = 0, w_lo = 0, w_hi = 0, ar_lo = 0, ar_hi = 0;
    logic [3:0] bad_b = 4'd0, bad_rd = 4'd0, bad_rr = 4'd0;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         wlog[$];
    logic [31:0] arlog[$];
    logic [31:0] mem [0:255];

    int   aw_wait, aw_need, w_wait, w_need, ar_wait, ar_need;
    logic aw_have, w_have;
    logic [31:0] aw_addr, w_data;

    function automatic int draw(input int lo, input int hi);
        if (hi <= lo) return lo;
        return lo + int'($urandom_range(hi - lo));
    endfunction

    function automatic bit bad_at(input logic [3:0] m, input logic [31:0] a);
        logic [1:0] i;
        i = a[3:2];
        return (a < 32'd16) && m[i];
    endfunction

    assign M_AXI_AWREADY = (aw_wait >= aw_need);
    assign M_AXI_WREADY  = (w_wait >= w_need);
    assign M_AXI_ARREADY = (ar_wait >= ar_need);

    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] sl_wa, sl_wd;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign sl_wa = aw_hs ? M_AXI_AWADDR : aw_addr;
    assign sl_wd = w_hs ? M_AXI_WDATA : w_data;

    // Memory slave: stall counters frozen while VALID waits, B/R answered next cycle
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_have <= 1'b0; w_have <= 1'b0; aw_addr <= '0; w_data <= '0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
            aw_wait <= 0; aw_need <= 0; w_wait <= 0; w_need <= 0; ar_wait <= 0; ar_need <= 0;
        end else begin
            if (!M_AXI_AWVALID || M_AXI_AWREADY) begin
                aw_wait <= 0; aw_need <= draw(aw_lo, aw_hi);
            end else aw_wait <= aw_wait + 1;
            if (!M_AXI_WVALID || M_AXI_WREADY) begin
                w_wait <= 0; w_need <= draw(w_lo, w_hi);
            end else w_wait <= w_wait + 1;
            if (!M_AXI_ARVALID || M_AXI_ARREADY) begin
                ar_wait <= 0; ar_need <= draw(ar_lo, ar_hi);
            end else ar_wait <= ar_wait + 1;

            if (aw_hs) begin aw_have <= 1'b1; aw_addr <= M_AXI_AWADDR; end
            if (w_hs)  begin w_have  <= 1'b1; w_data  <= M_AXI_WDATA;  end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if ((aw_have || aw_hs) && (w_have || w_hs)) begin
                mem[sl_wa[9:2]] <= sl_wd;
                wlog.push_back({sl_wa, sl_wd});
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP  <= bad_at(bad_b, sl_wa) ? 2'b10 : 2'b00;
                aw_have <= 1'b0;
                w_have  <= 1'b0;
            end

            if (ar_hs) begin
                arlog.push_back(M_AXI_ARADDR);
                M_AXI_RVALID <= 1'b1;
                M_AXI_RDATA  <= mem[M_AXI_ARADDR[9:2]] ^
                                (bad_at(bad_rd, M_AXI_ARADDR) ? 32'h1 : 32'h0);
                M_AXI_RRESP  <= bad_at(bad_rr, M_AXI_ARADDR) ? 2'b10 : 2'b00;
            end else if (M_AXI_RVALID && M_AXI_RREADY) begin
                M_AXI_RVALID <= 1'b0;
            end
        end
    end

    // ---------------- protocol monitor, sampled mid-cycle
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_pa = '0, w_pd = '0, ar_pa = '0;
    logic [3:0]  w_ps = '0;
    int stab_err = 0, strb_err = 0, last_r_cyc = 0;
    int aw_cyc = 0, w_cyc = 0, n_aw_first = 0, n_w_first = 0, n_same = 0;

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if ((aw_pend && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_pa)) ||
                (w_pend && (!M_AXI_WVALID || M_AXI_WDATA != w_pd || M_AXI_WSTRB != w_ps)) ||
                (ar_pend && (!M_AXI_ARVALID || M_AXI_ARADDR != ar_pa)))
                stab_err <= stab_err + 1;
            if (M_AXI_WVALID && M_AXI_WSTRB != 4'hF) strb_err <= strb_err + 1;
        end
        aw_pend <= ARESETN && M_AXI_AWVALID && !M_AXI_AWREADY;
        w_pend  <= ARESETN && M_AXI_WVALID && !M_AXI_WREADY;
        ar_pend <= ARESETN && M_AXI_ARVALID && !M_AXI_ARREADY;
        aw_pa <= M_AXI_AWADDR; w_pd <= M_AXI_WDATA; w_ps <= M_AXI_WSTRB; ar_pa <= M_AXI_ARADDR;
        if (M_AXI_RVALID && M_AXI_RREADY) last_r_cyc <= cyc;
        if (aw_hs) aw_cyc <= cyc;
        if (w_hs)  w_cyc  <= cyc;
        if (M_AXI_BVALID && M_AXI_BREADY) begin
            if (aw_cyc < w_cyc)      n_aw_first <= n_aw_first + 1;
            else if (w_cyc < aw_cyc) n_w_first  <= n_w_first + 1;
            else                     n_same     <= n_same + 1;
        end
    end

    // ---------------- reference model
    function automatic logic [31:0] model_data(input int k);
        logic [32:0] d;
        d = 33'h0101FFFF;
        for (int i = 0; i < k; i++) begin
            d = {1'b0, d[31:0]} * 2;
            d = {1'b0, d[31:0] + {31'd0, d[32]} + 32'd1};
        end
        return d[31:0];
    endfunction

    function automatic int model_err(input logic [3:0] bb, input logic [3:0] br,
                                     input logic [3:0] rr);
        int e = 0;
        for (int k = 0; k < NREG; k++) e += int'(bb[k]) + int'(br[k] | rr[k]);
        return (e > 255) ? 255 : e;
    endfunction

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int aw_lo, aw_hi, w_lo, w_hi, ar_lo, ar_hi;
        logic [3:0] bad_b, bad_rd, bad_rr;
        bit mid_start;
        int exp_err;
        bit exp_pass;
    } run_t;

    task automatic do_run(input string tag, input run_t c);
        int n, wb, rb, sb, done_cyc;
        bit zw;
        aw_lo = c.aw_lo; aw_hi = c.aw_hi; w_lo = c.w_lo; w_hi = c.w_hi;
        ar_lo = c.ar_lo; ar_hi = c.ar_hi;
        bad_b = c.bad_b; bad_rd = c.bad_rd; bad_rr = c.bad_rr;
        zw = (c.aw_hi == 0) && (c.w_hi == 0) && (c.ar_hi == 0);
        wb = wlog.size(); rb = arlog.size(); sb = stab_err;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0; n = 1;
        check({tag, "/busy_done_after_start"}, {busy, done}, 2'b10);
        if (c.mid_start) begin
            repeat (3) begin @(negedge ACLK); n++; end
            start = 1'b1;
            @(negedge ACLK); n++;
            start = 1'b0;
        end
        while (!done && n < 1000) begin @(negedge ACLK); n++; end
        done_cyc = cyc;
        check({tag, "/done"}, done, 1'b1);
        check({tag, "/err_count"}, err_count, c.exp_err);
        check({tag, "/pass"}, pass, c.exp_pass);
        check({tag, "/busy_at_done"}, busy, 1'b0);
        if (zw) check({tag, "/latency"}, n, NREG * PER + 1);
        check({tag, "/r_to_done"}, done_cyc - last_r_cyc, 2);
        check({tag, "/n_writes"}, wlog.size() - wb, NREG);
        check({tag, "/n_reads"}, arlog.size() - rb, NREG);
        for (int k = 0; k < NREG; k++) begin
            if (wb + k < wlog.size())
                check($sformatf("%s/wr%0d", tag, k), wlog[wb + k],
                      {32'(k * STEP), model_data(k)});
            if (rb + k < arlog.size())
                check($sformatf("%s/rd%0d", tag, k), arlog[rb + k], 32'(k * STEP));
        end
        check({tag, "/payload_stable"}, stab_err - sb, 0);
        repeat (2) @(negedge ACLK);
        check({tag, "/done_held"}, {done, busy}, 2'b10);
    endtask

    run_t tbl[9];
    run_t rc;
    bit   found, any_act;

    initial begin
        //        aw    w     ar    bad_b    bad_rd   bad_rr  mid  err pass
        tbl[0] = '{0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1, 1'b0};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4, 1'b0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        tbl[4] = '{0, 5, 0, 5, 0, 5, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        tbl[5] = '{3, 3, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        tbl[6] = '{0, 0, 3, 3, 2, 2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 1'b1};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 2, 1'b0};

        // Outputs in reset
        repeat (3) @(negedge ACLK);
        check("rst_ctrl", {busy, done, pass, err_count}, 0);
        check("rst_valid_ready",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("rst_payload", |{M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR}, 0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        for (int i = 0; i < 9; i++) do_run($sformatf("tbl%0d", i), tbl[i]);

        // Random stalls and random fault masks against the error model
        for (int i = 0; i < 6; i++) begin
            rc = tbl[0];
            rc.aw_hi = int'($urandom_range(5)); rc.w_hi = int'($urandom_range(5));
            rc.ar_hi = int'($urandom_range(5));
            rc.bad_b  = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
            rc.bad_rd = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
            rc.bad_rr = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
            rc.exp_err  = model_err(rc.bad_b, rc.bad_rd, rc.bad_rr);
            rc.exp_pass = (rc.exp_err == 0);
            do_run($sformatf("rnd%0d", i), rc);
        end

        // Reset in RD_DATA of register 2
        rc = tbl[0];
        aw_lo = 0; aw_hi = 0; w_lo = 0; w_hi = 0; ar_lo = 0; ar_hi = 0;
        bad_b = 4'd0; bad_rd = 4'd0; bad_rr = 4'd0;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (M_AXI_ARVALID && M_AXI_ARREADY && M_AXI_ARADDR == 32'h8) found = 1'b1;
            else @(negedge ACLK);
        end
        check("midrst/ar_k2_seen", found, 1'b1);
        @(posedge ACLK); #1;
        check("midrst/in_rd_data", {M_AXI_RREADY, busy}, 2'b11);
        ARESETN = 1'b0;
        #1;
        check("midrst/ctrl_zero", {busy, done, pass, err_count}, 0);
        check("midrst/valid_ready_zero",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("midrst/payload_zero",
              |{M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR}, 0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        any_act = 1'b0;
        repeat (8) begin
            @(negedge ACLK);
            any_act |= M_AXI_AWVALID | M_AXI_WVALID | M_AXI_ARVALID | M_AXI_BREADY |
                       M_AXI_RREADY | busy | done;
        end
        check("midrst/no_resume", any_act, 1'b0);
        do_run("after_rst", rc);

        check("wstrb_all_ones", strb_err, 0);
`ifdef AXIL_REGTEST_CONCURRENT_EN
        check("order/w_before_aw_seen", n_w_first > 0, 1'b1);
        check("order/aw_before_w_seen", n_aw_first > 0, 1'b1);
`else
        check("order/w_never_before_aw", n_w_first + n_same, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
